ir_queue_dlx: RTL
=================

IR_QUEUE_DLX -- requirements
Module: ir_queue_dlx

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue entries; power of two, 2..16.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000: word presented on IR_OUT while empty.
REQ-003 Ports, clock and reset first:
- CLK, input, 1: sole clock, rising edge.
- RST_N, input, 1: asynchronous active-low reset.
- IN_VALID, input, 1: D_IN holds a fetched instruction.
- IN_READY, output, 1: queue accepts D_IN.
- D_IN, input, 32: instruction word.
- FLUSH, input, 1: synchronous queue discard (branch redirect).
- OUT_VALID, output, 1: head entry valid.
- OUT_READY, input, 1: consumer takes head this cycle.
- IR_OUT, output, 32: head instruction word.
- OPCODE, output, 6: IR_OUT[31:26].
- RS1, output, 5: IR_OUT[25:21].
- RS2, output, 5: IR_OUT[20:16].
- SEXT_IMM, output, 32: IR_OUT[15:0] sign-extended.
- ALUF, output, 3: ALU function.
- ALUFP, output, 6: FP/SIMD function.
- C_ADDR, output, 5: destination register.
- LINK, output, 1: head is a link-writing jump.
- COUNT, output, $clog2(DEPTH+1): occupied entries.
REQ-004 One clock; reset is asynchronous and active-low; clock port CLK, reset port RST_N.

Function
REQ-005 Push = IN_VALID && IN_READY at rising CLK; pop = OUT_VALID && OUT_READY.
REQ-006 IN_READY = (COUNT < DEPTH), registered-state only; no pass-through when full, even with OUT_READY=1.
REQ-007 OUT_VALID = (COUNT != 0); push-to-OUT_VALID latency 1 cycle (without bypass, REQ-017).
REQ-008 Simultaneous push and pop: COUNT unchanged, order preserved, head advances.
REQ-009 Read/write pointers $clog2(DEPTH) bits, wrap modulo DEPTH; COUNT never exceeds DEPTH or underflows.
REQ-010 FLUSH=1: next edge sets COUNT=0, pointers 0; same-cycle push and pop are discarded.
REQ-011 Empty: IR_OUT=NOP_WORD, all decode outputs derived from NOP_WORD.
REQ-012 Decode, combinational from IR_OUT: R-type iff IR_OUT[31:28]==4'b0000; rd=IR_OUT[15:11] for R-type, else IR_OUT[20:16].
REQ-013 ALUF = IR_OUT[2:0] for R-type, else IR_OUT[28:26].
REQ-014 ALUFP = {3'b000, IR_OUT[28:26]} when IR_OUT[31:29]==3'b111, else IR_OUT[5:0].
REQ-015 LINK = (IR_OUT[31:29]==3'b010 && IR_OUT[26]==1); C_ADDR=5'd31 when LINK, else rd.

Reset
REQ-016 RST_N low: immediately COUNT=0, pointers 0, OUT_VALID=0, IN_READY=0, IR_OUT=NOP_WORD; IN_READY=1 from first edge after release; assertion mid-transfer discards all entries; storage RAM not cleared.

Configuration
REQ-017 Macro IR_QUEUE_BYPASS_EN: defined -> when COUNT==0, IN_VALID=1, FLUSH=0, OUT_VALID=1 and IR_OUT=D_IN same cycle; if OUT_READY also 1, word consumed without being written (COUNT stays 0). Undefined -> OUT_VALID strictly from stored entries, 1-cycle latency.

Structure
REQ-018 Shared package dlx_ir_pkg: field-position constants (OPC_MSB/LSB, RS1, RS2, RD_R, RD_I, IMM), REG_LINK=5'd31, OPC_RTYPE_HI=4'b0000, OPC_FP_HI=3'b111, OPC_JMP_HI=3'b010.
REQ-019 One combinational sub-module ir_decode_dlx (32-bit word in, OPCODE/RS1/RS2/SEXT_IMM/ALUF/ALUFP/C_ADDR/LINK out); queue storage/pointers in ir_queue_dlx.

Verification
REQ-020 DEPTH=4, push 32'h2022_0005, 32'h0043_2820 on consecutive cycles, OUT_READY=0 -> COUNT=2; IR_OUT=32'h2022_0005, SEXT_IMM=32'h0000_0005, C_ADDR=2, ALUF=0.
REQ-021 Push 6 words with OUT_READY=0 -> IN_READY=0 after 4th, COUNT=4, words 5-6 not accepted; then pop 4 -> original order, COUNT=0, IR_OUT=NOP_WORD.
REQ-022 Head 32'h0043_2820 (R-type) -> C_ADDR=5, ALUF=3'b000, ALUFP=6'h20; head 32'hE400_FFFF -> ALUFP=6'h01, SEXT_IMM=32'hFFFF_FFFF.
REQ-023 Head 32'h4C20_0000 -> LINK=1, C_ADDR=31.
REQ-024 COUNT=3, FLUSH=1 with IN_VALID=1, OUT_READY=1 -> next cycle COUNT=0, OUT_VALID=0; RST_N pulsed low mid-stream -> same state immediately, without a clock edge.
REQ-025 IR_QUEUE_BYPASS_EN defined, empty, IN_VALID=1, OUT_READY=1, D_IN=32'h2022_0005 -> same-cycle OUT_VALID=1, IR_OUT=D_IN, COUNT stays 0; undefined -> OUT_VALID one cycle later.

Source files
------------

// File: rtl/dlx_ir_pkg.sv
// Shared DLX instruction-field layout and decode constants for the IR queue slice.
package dlx_ir_pkg;

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 26;
    localparam int unsigned RS1_MSB  = 25;
    localparam int unsigned RS1_LSB  = 21;
    localparam int unsigned RS2_MSB  = 20;
    localparam int unsigned RS2_LSB  = 16;
    localparam int unsigned RD_R_MSB = 15;
    localparam int unsigned RD_R_LSB = 11;
    localparam int unsigned RD_I_MSB = 20;
    localparam int unsigned RD_I_LSB = 16;
    localparam int unsigned IMM_MSB  = 15;
    localparam int unsigned IMM_LSB  = 0;
    localparam int unsigned FN_MSB   = 5;
    localparam int unsigned FN_LSB   = 0;

    localparam logic [4:0] REG_LINK     = 5'd31;
    localparam logic [3:0] OPC_RTYPE_HI = 4'b0000;
    localparam logic [2:0] OPC_FP_HI    = 3'b111;
    localparam logic [2:0] OPC_JMP_HI   = 3'b010;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/ir_decode_dlx.sv
// Combinational field decode of a DLX instruction word.
module ir_decode_dlx
    import dlx_ir_pkg::*;
(
    input  logic [31:0] IR_IN,
    output logic [5:0]  OPCODE,
    output logic [4:0]  RS1,
    output logic [4:0]  RS2,
    output logic [31:0] SEXT_IMM,
    output logic [2:0]  ALUF,
    output logic [5:0]  ALUFP,
    output logic [4:0]  C_ADDR,
    output logic        LINK
);

    logic       rtype;
    logic       fp_op;
    logic       jmp_op;
    logic [4:0] rd;

    always_comb begin
        rtype    = (IR_IN[OPC_MSB -: 4] == OPC_RTYPE_HI);
        fp_op    = (IR_IN[OPC_MSB -: 3] == OPC_FP_HI);
        jmp_op   = (IR_IN[OPC_MSB -: 3] == OPC_JMP_HI);
        OPCODE   = IR_IN[OPC_MSB:OPC_LSB];
        RS1      = IR_IN[RS1_MSB:RS1_LSB];
        RS2      = IR_IN[RS2_MSB:RS2_LSB];
        SEXT_IMM = sext16(IR_IN[IMM_MSB:IMM_LSB]);
        rd       = rtype ? IR_IN[RD_R_MSB:RD_R_LSB] : IR_IN[RD_I_MSB:RD_I_LSB];
        ALUF     = rtype ? IR_IN[FN_LSB +: 3] : IR_IN[OPC_LSB +: 3];
        // FP/SIMD group carries its function in the low opcode bits
        ALUFP    = fp_op ? {3'b000, IR_IN[OPC_LSB +: 3]} : IR_IN[FN_MSB:FN_LSB];
        LINK     = jmp_op && IR_IN[OPC_LSB];
        C_ADDR   = LINK ? REG_LINK : rd;
    end

endmodule

// File: rtl/ir_queue_dlx.sv
// Instruction-register FIFO with combinational head decode.
// Optional same-cycle empty-queue bypass: define IR_QUEUE_BYPASS_EN.
module ir_queue_dlx
    import dlx_ir_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [31:0]                D_IN,
    input  logic                       FLUSH,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [31:0]                IR_OUT,
    output logic [5:0]                 OPCODE,
    output logic [4:0]                 RS1,
    output logic [4:0]                 RS2,
    output logic [31:0]                SEXT_IMM,
    output logic [2:0]                 ALUF,
    output logic [5:0]                 ALUFP,
    output logic [4:0]                 C_ADDR,
    output logic                       LINK,
    output logic [$clog2(DEPTH+1)-1:0] COUNT
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          rdy_q;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          rd_en;

    always_comb begin
        empty    = (count_q == '0);
        IN_READY = rdy_q && (count_q < DEPTH_C);
`ifdef IR_QUEUE_BYPASS_EN
        bypass   = rdy_q && empty && IN_VALID && !FLUSH;
`else
        bypass   = 1'b0;
`endif
        OUT_VALID = !empty || bypass;
        if (!empty)
            IR_OUT = mem[rd_ptr];
        else if (bypass)
            IR_OUT = D_IN;
        else
            IR_OUT = NOP_WORD;
        push  = IN_VALID && IN_READY;
        pop   = OUT_VALID && OUT_READY;
        // a bypassed word that is consumed the same cycle is never stored
        wr_en = push && !(bypass && OUT_READY) && !FLUSH;
        rd_en = pop && !empty && !FLUSH;
        COUNT = count_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (FLUSH) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + PW'(1);
                if (rd_en)
                    rd_ptr <= rd_ptr + PW'(1);
                case ({wr_en, rd_en})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_ptr] <= D_IN;
    end

    ir_decode_dlx u_decode (
        .IR_IN    (IR_OUT),
        .OPCODE   (OPCODE),
        .RS1      (RS1),
        .RS2      (RS2),
        .SEXT_IMM (SEXT_IMM),
        .ALUF     (ALUF),
        .ALUFP    (ALUFP),
        .C_ADDR   (C_ADDR),
        .LINK     (LINK)
    );

endmodule
